// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU execute stage slice.
package alu_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } alu_state_t;

endpackage

// File: rtl/alu_exec_if.sv
// Start/busy/done handshake, operand read buses and status flags of the execute stage.
interface alu_exec_if #(
    parameter int WIDTH = alu_pkg::DATA_W
) ();
    import alu_pkg::*;

    logic             start;
    alu_op_t          op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic             result_oe;
    logic             flag_z;
    logic             flag_c;
    logic             flag_n;

    modport master (
        output start, op, operand_a, operand_b,
        input  busy, done, result_oe, flag_z, flag_c, flag_n
    );

    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, done, result_oe, flag_z, flag_c, flag_n
    );

endinterface

// File: rtl/shift_add_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps in total.
// The first step is folded into the load cycle so the product is final WIDTH-1 cycles later.
module shift_add_multiplier #(
    parameter int WIDTH = alu_pkg::DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic [2*WIDTH-1:0] product
);

    localparam int              CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;

    // Add A into the high half (carry kept in bit WIDTH of the sum), then shift the accumulator right.
    function automatic logic [2*WIDTH-1:0] mac_step(
        input logic [2*WIDTH-1:0] acc,
        input logic [WIDTH-1:0]   a_v,
        input logic               b_bit
    );
        logic [WIDTH:0] sum;
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_bit ? {1'b0, a_v} : '0);
        return {sum, acc[WIDTH-1:1]};
    endfunction

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (load) begin
            r_acc  <= mac_step('0, a, b[0]);
            r_a    <= a;
            r_b    <= b >> 1;
            r_cnt  <= CNT_ONE;
            r_busy <= (WIDTH > 1);
        end else if (r_busy) begin
            r_acc <= mac_step(r_acc, r_a, r_b[0]);
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + CNT_ONE;
            if (r_cnt == CNT_LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy    = r_busy;
    assign product = r_acc;

endmodule

// File: rtl/alu_exec_stage.sv
// Multi-cycle execute stage: takes operands from the bank read buses, computes one of
// eight ops and drives the result onto the shared tri-state write bus for one cycle.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    alu_exec_if.slave        bus,
    output wire [WIDTH-1:0]  result
);

    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_EXEC = S_EXEC;
    localparam logic [1:0] ST_MUL  = S_MUL;
    localparam logic [1:0] ST_DONE = S_DONE;

    logic [1:0]         r_state;
    alu_op_t            r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic               r_flag_z;
    logic               r_flag_c;
    logic               r_flag_n;

    logic               w_accept;
    logic               w_mul_load;
    logic               w_mul_busy;
    logic [2*WIDTH-1:0] w_product;
    logic               w_capture;
    logic               w_drive;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_c;

    assign w_accept   = (r_state == ST_IDLE) && bus.start;
    assign w_mul_load = w_accept && (bus.op == OP_MUL);

    shift_add_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (w_mul_load),
        .a       (bus.operand_a),
        .b       (bus.operand_b),
        .busy    (w_mul_busy),
        .product (w_product)
    );

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        case (r_op)
            OP_ADD: {w_alu_c, w_alu_res} = {1'b0, r_a} + {1'b0, r_b};
            OP_SUB: {w_alu_c, w_alu_res} = {1'b0, r_a} - {1'b0, r_b};
            OP_AND: w_alu_res = r_a & r_b;
            OP_OR:  w_alu_res = r_a | r_b;
            OP_XOR: w_alu_res = r_a ^ r_b;
            OP_SHL: begin
                w_alu_res = {r_a[WIDTH-2:0], 1'b0};
                w_alu_c   = r_a[WIDTH-1];
            end
            OP_SHR: begin
                w_alu_res = {1'b0, r_a[WIDTH-1:1]};
                w_alu_c   = r_a[0];
            end
            default: begin
                w_alu_res = w_product[WIDTH-1:0];
                w_alu_c   = |w_product[2*WIDTH-1:WIDTH];
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= OP_ADD;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_a     <= bus.operand_a;
                        r_b     <= bus.operand_b;
                        r_state <= (bus.op == OP_MUL) ? ST_MUL : ST_EXEC;
                    end
                end
                ST_EXEC: r_state <= ST_DONE;
                ST_MUL:  if (!w_mul_busy) r_state <= ST_DONE;
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Result and flags are written only on the edge that enters DONE, then held.
    assign w_capture = (r_state == ST_EXEC) || ((r_state == ST_MUL) && !w_mul_busy);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
            r_flag_n <= 1'b0;
        end else if (w_capture) begin
            r_result <= w_alu_res;
            r_flag_z <= (w_alu_res == '0);
            r_flag_c <= w_alu_c;
            r_flag_n <= w_alu_res[WIDTH-1];
        end
    end

    // Status comes straight from the state register, so reset silences the bus at once.
    assign w_drive       = (r_state == ST_DONE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = w_drive;
    assign bus.result_oe = w_drive;
    assign bus.flag_z    = r_flag_z;
    assign bus.flag_c    = r_flag_c;
    assign bus.flag_n    = r_flag_n;
    assign result        = w_drive ? r_result : 'z;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench for alu_exec_stage with hand-computed expected results.
module tb_alu_exec_stage;
    import alu_pkg::*;

    localparam int W = DATA_W;

    logic         clk = 1'b0;
    logic         reset;
    wire [W-1:0]  result;
    int           n_tests = 0;
    int           n_fail  = 0;

    alu_exec_if #(.WIDTH(W)) bus ();

    alu_exec_stage #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Released bus: enable low and nothing driven (2-state simulators show the undriven net as 0).
    function automatic logic bus_released();
        return !bus.result_oe && ((result === {W{1'bz}}) || (result === {W{1'b0}}));
    endfunction

    task automatic run_op(input string tag, input alu_op_t op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res,
                          input logic exp_c, input logic exp_z, input logic exp_n);
        int lat;
        int exp_lat;
        exp_lat = (op == OP_MUL) ? W : 1;
        bus.start = 1'b1;
        bus.op = op;
        bus.operand_a = a;
        bus.operand_b = b;
        tick();
        bus.start = 1'b0;
        bus.operand_a = ~a;
        bus.operand_b = b ^ 8'h3C;
        check({tag, "_busy"}, 32'(bus.busy), 1);
        lat = 0;
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_oe"}, 32'(bus.result_oe), 1);
        check({tag, "_c"}, 32'(bus.flag_c), 32'(exp_c));
        check({tag, "_z"}, 32'(bus.flag_z), 32'(exp_z));
        check({tag, "_n"}, 32'(bus.flag_n), 32'(exp_n));
        tick();
        check({tag, "_done_pulse"}, 32'(bus.done), 0);
        check({tag, "_busy_end"}, 32'(bus.busy), 0);
        check({tag, "_released"}, 32'(bus_released()), 1);
        check({tag, "_flags_hold"}, 32'({bus.flag_c, bus.flag_z, bus.flag_n}),
              32'({exp_c, exp_z, exp_n}));
    endtask

    initial begin
        int  lat;
        logic saw_done;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = OP_ADD;
        bus.operand_a = '0;
        bus.operand_b = '0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_released", 32'(bus_released()), 1);
        check("rst_flags", 32'({bus.flag_c, bus.flag_z, bus.flag_n}), 0);
        reset = 1'b0;
        tick();

        run_op("add",   OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0);
        run_op("sub_eq", OP_SUB, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0);
        run_op("sub_lt", OP_SUB, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b1);

        // Reset four cycles into a multiply: everything aborts, flags from the SUB are cleared.
        bus.start = 1'b1;
        bus.op = OP_MUL;
        bus.operand_a = 8'h0F;
        bus.operand_b = 8'h0F;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        check("mulrst_busy_before", 32'(bus.busy), 1);
        reset = 1'b1;
        #1;
        check("mulrst_busy", 32'(bus.busy), 0);
        check("mulrst_done", 32'(bus.done), 0);
        check("mulrst_released", 32'(bus_released()), 1);
        check("mulrst_flags", 32'({bus.flag_c, bus.flag_z, bus.flag_n}), 0);
        saw_done = 1'b0;
        repeat (2) begin
            tick();
            if (bus.done) saw_done = 1'b1;
        end
        reset = 1'b0;
        repeat (12) begin
            tick();
            if (bus.done || bus.result_oe) saw_done = 1'b1;
        end
        check("mulrst_no_done", 32'(saw_done), 0);
        check("mulrst_idle", 32'(bus.busy), 0);

        run_op("mul",      OP_MUL, 8'h12, 8'h0D, 8'hEA, 1'b0, 1'b0, 1'b1);
        run_op("mul_ovf",  OP_MUL, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0);
        run_op("mul_full", OP_MUL, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);

        // start held high across a multiply while the read buses churn.
        bus.start = 1'b1;
        bus.op = OP_MUL;
        bus.operand_a = 8'h12;
        bus.operand_b = 8'h0D;
        tick();
        lat = 0;
        while (!bus.done && lat < 20) begin
            bus.operand_a = W'($urandom);
            bus.operand_b = W'($urandom);
            bus.op = alu_op_t'(3'($urandom_range(0, 7)));
            tick();
            lat++;
        end
        check("hold_latency", 32'(lat), 32'(W));
        check("hold_result", 32'(result), 32'h0000_00EA);
        bus.op = OP_ADD;
        bus.operand_a = 8'h01;
        bus.operand_b = 8'h02;
        tick();
        check("hold_idle_gap", 32'(bus.busy), 0);
        tick();
        check("hold_reaccept", 32'(bus.busy), 1);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
        check("hold2_latency", 32'(lat), 1);
        check("hold2_result", 32'(result), 32'h0000_0003);
        tick();

        run_op("shl", OP_SHL, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
        run_op("shr", OP_SHR, 8'h81, 8'h00, 8'h40, 1'b1, 1'b0, 1'b0);
        run_op("and", OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
        run_op("or",  OP_OR,  8'h0F, 8'h80, 8'h8F, 1'b0, 1'b0, 1'b1);
        run_op("xor", OP_XOR, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0);

        repeat (3) begin
            bus.operand_a = W'($urandom);
            bus.operand_b = W'($urandom);
            tick();
            check("idle_flags", 32'({bus.flag_c, bus.flag_z, bus.flag_n}), 32'b010);
            check("idle_released", 32'(bus_released()), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
